// File: rtl/ins_packer.sv
// ins_packer
//   Packs RATIO consecutive INWIDTH-bit samples from the InstMod `ins` bus
//   into one wide word. The word is presented on a registered valid/ready
//   output with per-lane keep bits and a frame-end flag. A sample with
//   in_last set flushes a partially filled word.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   in_valid   sample on in_data is valid
//   in_ready   block accepts a sample this cycle (0 while rst_n is low)
//   in_data    INWIDTH-bit sample
//   in_last    sample ends a frame; the word is flushed after it
//   out_valid  packed word valid
//   out_ready  downstream accepts the word
//   out_data   INWIDTH*RATIO packed word
//   out_keep   one bit per lane, 1 = lane holds a real sample
//   out_last   word ends a frame
module ins_packer #(
  parameter int INWIDTH   = 8,
  parameter int RATIO     = 4,
  parameter int FIRST_LSB = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INWIDTH-1:0]         in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INWIDTH*RATIO-1:0]   out_data,
  output logic [RATIO-1:0]           out_keep,
  output logic                       out_last
);

  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int WW = INWIDTH * RATIO;
  localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [CW-1:0]   r_count;
  logic [WW-1:0]   r_acc_data;
  logic [RATIO-1:0] r_acc_keep;

  logic [WW-1:0]   r_hold_data;
  logic [RATIO-1:0] r_hold_keep;
  logic            r_hold_last;

  logic            r_out_valid;
  logic [WW-1:0]   r_out_data;
  logic [RATIO-1:0] r_out_keep;
  logic            r_out_last;

  logic            w_accept;
  logic            w_complete;
  logic            w_slot_free;
  logic [RATIO-1:0] w_hit;
  logic [WW-1:0]   w_word_data;
  logic [RATIO-1:0] w_word_keep;

  assign in_ready    = rst_n && (r_state == FILL);
  assign w_accept    = in_valid && in_ready;
  assign w_complete  = w_accept && ((r_count == LAST_IDX) || in_last);
  // The output register can take a new word if it is empty or being drained now.
  assign w_slot_free = !r_out_valid || out_ready;

  // Each lane knows at elaboration time which sample index lands in it, so the
  // merge is a per-lane compare against the count rather than a variable shift.
  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_lane
      localparam int SLOT = (FIRST_LSB != 0) ? gi : (RATIO - 1 - gi);
      assign w_hit[gi] = (r_count == CW'(SLOT));
      assign w_word_data[gi*INWIDTH +: INWIDTH] =
        w_hit[gi] ? in_data : r_acc_data[gi*INWIDTH +: INWIDTH];
      assign w_word_keep[gi] = w_hit[gi] | r_acc_keep[gi];
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FILL: begin
        if (w_complete && !w_slot_free) begin
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (w_slot_free) begin
          w_state_next = FILL;
        end
      end
      default: w_state_next = FILL;
    endcase
  end

  // Lane counter and accumulator
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_acc_data <= '0;
      r_acc_keep <= '0;
    end else if (w_complete) begin
      r_count    <= '0;
      r_acc_data <= '0;
      r_acc_keep <= '0;
    end else if (w_accept) begin
      r_count    <= r_count + 1'b1;
      r_acc_data <= w_word_data;
      r_acc_keep <= w_word_keep;
    end
  end

  // Hold register: parks a completed word while the output slot is occupied.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold_data <= '0;
      r_hold_keep <= '0;
      r_hold_last <= 1'b0;
    end else if (w_complete && !w_slot_free) begin
      r_hold_data <= w_word_data;
      r_hold_keep <= w_word_keep;
      r_hold_last <= in_last;
    end
  end

  // Output register. A parked word always goes out before any newer word;
  // in HOLD no sample is accepted, so the two load sources never collide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
    end else if ((r_state == HOLD) && w_slot_free) begin
      r_out_valid <= 1'b1;
      r_out_data  <= r_hold_data;
      r_out_keep  <= r_hold_keep;
      r_out_last  <= r_hold_last;
    end else if (w_complete && w_slot_free) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_word_data;
      r_out_keep  <= w_word_keep;
      r_out_last  <= in_last;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_ins_packer.sv
// tb_ins_packer
//   Drives two ins_packer instances (FIRST_LSB=1 and FIRST_LSB=0) from the
//   same stimulus. A queue-based reference model built from the packing
//   rules predicts every word, in_ready and out_valid; directed sequences
//   add explicit constant checks, then a long randomized run follows.
module tb_ins_packer;

  localparam int W  = 8;
  localparam int R  = 4;
  localparam int WW = W * R;

  typedef struct packed {
    logic [WW-1:0] data;
    logic [R-1:0]  keep;
    logic          last;
  } word_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_ready;

  logic          in_ready0, in_ready1;
  logic          out_valid0, out_valid1;
  logic [WW-1:0] out_data0, out_data1;
  logic [R-1:0]  out_keep0, out_keep1;
  logic          out_last0, out_last1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ins_packer #(.INWIDTH(W), .RATIO(R), .FIRST_LSB(1)) u_lsb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_keep(out_keep0), .out_last(out_last0)
  );

  ins_packer #(.INWIDTH(W), .RATIO(R), .FIRST_LSB(0)) u_msb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_keep(out_keep1), .out_last(out_last1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Words inside the DUT (output register plus parked word) sit in q0/q1;
  // the samples of the word being filled sit in part.
  word_t        q0[$];
  word_t        q1[$];
  logic [W-1:0] part[$];
  word_t        w0, w1;
  logic         exp_ready;

  always @(negedge clk) begin
    if (!rst_n) begin
      check_eq("rst_in_ready_lsb", in_ready0, 1'b0);
      check_eq("rst_in_ready_msb", in_ready1, 1'b0);
      q0.delete();
      q1.delete();
      part.delete();
    end else begin
      exp_ready = (q0.size() < 2);
      check_eq("in_ready_lsb", in_ready0, exp_ready);
      check_eq("in_ready_msb", in_ready1, exp_ready);
      check_eq("out_valid_lsb", out_valid0, q0.size() > 0);
      check_eq("out_valid_msb", out_valid1, q1.size() > 0);
      if (q0.size() > 0) begin
        check_eq("data_lsb", out_data0, q0[0].data);
        check_eq("keep_lsb", out_keep0, q0[0].keep);
        check_eq("last_lsb", out_last0, q0[0].last);
        check_eq("data_msb", out_data1, q1[0].data);
        check_eq("keep_msb", out_keep1, q1[0].keep);
        check_eq("last_msb", out_last1, q1[0].last);
        if (out_ready) begin
          void'(q0.pop_front());
          void'(q1.pop_front());
        end
      end
      if (in_valid && exp_ready) begin
        part.push_back(in_data);
        if (part.size() == R || in_last) begin
          w0 = '0;
          w1 = '0;
          for (int k = 0; k < part.size(); k++) begin
            w0.data = w0.data | (WW'(part[k]) << (k * W));
            w0.keep[k] = 1'b1;
            w1.data = w1.data | (WW'(part[k]) << ((R - 1 - k) * W));
            w1.keep[R-1-k] = 1'b1;
          end
          w0.last = in_last;
          w1.last = in_last;
          q0.push_back(w0);
          q1.push_back(w1);
          part.delete();
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic l);
    int  n;
    logic acc;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    do begin
      @(negedge clk);
      acc = in_ready0;
      step();
      n++;
    end while (!acc && n < 1000);
    if (!acc) check_eq("send_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [WW-1:0] d0, input logic [R-1:0] k0,
                           input logic [WW-1:0] d1, input logic [R-1:0] k1, input logic l);
    $display("word %s: lsb=%h/%b msb=%h/%b last=%b", tag, out_data0, out_keep0,
             out_data1, out_keep1, out_last0);
    check_eq({tag, "_valid"}, out_valid0, 1'b1);
    check_eq({tag, "_data_lsb"}, out_data0, d0);
    check_eq({tag, "_keep_lsb"}, out_keep0, k0);
    check_eq({tag, "_data_msb"}, out_data1, d1);
    check_eq({tag, "_keep_msb"}, out_keep1, k1);
    check_eq({tag, "_last"}, out_last0, l);
  endtask

  int accepted;
  int cycles;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    check_eq("reset_out_valid", out_valid0, 1'b0);
    check_eq("reset_out_data", out_data0, '0);
    check_eq("reset_out_keep", out_keep0, '0);
    check_eq("reset_out_last", out_last0, 1'b0);
    rst_n = 1'b1;
    step();

    // Full word, both lane orders
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    check_out("full", 32'h44332211, 4'b1111, 32'h11223344, 4'b1111, 1'b0);

    // Partial word flushed by in_last
    send(8'hAA, 1'b0); send(8'hBB, 1'b1);
    check_out("flush", 32'h0000BBAA, 4'b0011, 32'hAABB0000, 4'b1100, 1'b1);

    // Next word restarts at the first lane; in_last on the first sample
    send(8'h77, 1'b1);
    check_out("single", 32'h00000077, 4'b0001, 32'h77000000, 4'b1000, 1'b1);

    // in_last on the final lane is one completion
    send(8'hC1, 1'b0); send(8'hC2, 1'b0); send(8'hC3, 1'b0); send(8'hC4, 1'b1);
    check_out("full_last", 32'hC4C3C2C1, 4'b1111, 32'hC1C2C3C4, 4'b1111, 1'b1);
    step();

    // Backpressure: second word parks in the hold register
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(W'(i), 1'b0);
    check_eq("hold_in_ready", in_ready0, 1'b0);
    check_out("held1", 32'h04030201, 4'b1111, 32'h01020304, 4'b1111, 1'b0);
    repeat (3) step();
    check_out("held1_stable", 32'h04030201, 4'b1111, 32'h01020304, 4'b1111, 1'b0);
    out_ready = 1'b1;
    step();
    check_out("held2", 32'h08070605, 4'b1111, 32'h05060708, 4'b1111, 1'b0);
    check_eq("hold_released_in_ready", in_ready0, 1'b1);
    step();
    check_eq("drained_valid", out_valid0, 1'b0);

    // Reset mid-word with a pending output word
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h90 + W'(i), 1'b0);
    send(8'hE0, 1'b0); send(8'hE1, 1'b0);
    rst_n = 1'b0;
    step();
    check_eq("midrst_out_valid", out_valid0, 1'b0);
    check_eq("midrst_in_ready", in_ready0, 1'b0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(8'h5A, 1'b0); send(8'h5B, 1'b0); send(8'h5C, 1'b0); send(8'h5D, 1'b0);
    check_out("after_rst", 32'h5D5C5B5A, 4'b1111, 32'h5A5B5C5D, 4'b1111, 1'b0);
    step();

    // Randomized run against the model
    accepted = 0;
    cycles   = 0;
    while (accepted < 10000 && cycles < 60000) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_data   = W'($urandom);
      in_last   = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 99) < 65);
      @(negedge clk);
      if (in_valid && in_ready0) accepted++;
      step();
      cycles++;
    end
    check_eq("random_samples_done", accepted >= 10000, 1'b1);
    $display("random phase: %0d samples in %0d cycles", accepted, cycles);

    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    check_eq("drain_queue_empty", q0.size(), 0);
    check_eq("drain_out_valid", out_valid0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
